// File: rtl/jtag_tap_target.sv
// jtag_tap_target: oversampled IEEE 1149.1 TAP responder with IR, IDCODE, BYPASS and one user DR
module jtag_tap_target #(
  parameter int                IR_LEN      = 4,
  parameter logic [31:0]       IDCODE_VAL  = 32'h1234_5093,
  parameter int                USER_DR_LEN = 32,
  parameter logic [IR_LEN-1:0] OP_IDCODE   = IR_LEN'(1),
  parameter logic [IR_LEN-1:0] OP_USER     = IR_LEN'(2)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   tck_i,
  input  logic                   tms_i,
  input  logic                   tdi_i,
  output logic                   tdo_o,
  output logic                   tdo_oe_o,
  output logic [3:0]             tap_state_o,
  output logic [IR_LEN-1:0]      ir_o,
  input  logic [USER_DR_LEN-1:0] user_dr_i,
  output logic [USER_DR_LEN-1:0] user_dr_o,
  output logic                   user_capture_o,
  output logic                   user_update_o
);
  typedef enum logic [3:0] {
    EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PAU_DR = 4'h3,
    SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
    EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PAU_IR = 4'hB,
    RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
  } tap_state_t;

  localparam logic [4:0] USER_MSB = 5'(USER_DR_LEN - 1);

  logic tck_m, tck_s, tck_d, tms_m, tms_s, tdi_m, tdi_s;
  logic rise, fall, is_id, is_user, bp;
  logic [IR_LEN-1:0] ir_sr;
  logic [31:0] dr_sr, dr_next;
  tap_state_t state, state_next;

  assign rise        = tck_s & ~tck_d;
  assign fall        = ~tck_s & tck_d;
  assign is_id       = ir_o == OP_IDCODE;
  assign is_user     = ir_o == OP_USER;
  assign tap_state_o = state;

  // two-flop synchronisers; tms/tdi share tck's stage so they are sampled aligned to the edge
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) {tck_m, tck_s, tck_d, tms_m, tms_s, tdi_m, tdi_s} <= '0;
    else {tck_m, tck_s, tck_d, tms_m, tms_s, tdi_m, tdi_s} <= {tck_i, tck_m, tck_s, tms_i, tms_m, tdi_i, tdi_m};

  // TAP state register, advanced only on a detected TCK rise
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) state <= TLR;
    else if (rise) state <= state_next;

  // 1149.1 transition table
  always_comb begin
    state_next = state;
    case (state)
      TLR:    state_next = tms_s ? TLR    : RTI;
      RTI:    state_next = tms_s ? SEL_DR : RTI;
      SEL_DR: state_next = tms_s ? SEL_IR : CAP_DR;
      CAP_DR: state_next = tms_s ? EX1_DR : SH_DR;
      SH_DR:  state_next = tms_s ? EX1_DR : SH_DR;
      EX1_DR: state_next = tms_s ? UPD_DR : PAU_DR;
      PAU_DR: state_next = tms_s ? EX2_DR : PAU_DR;
      EX2_DR: state_next = tms_s ? UPD_DR : SH_DR;
      UPD_DR: state_next = tms_s ? SEL_DR : RTI;
      SEL_IR: state_next = tms_s ? TLR    : CAP_IR;
      CAP_IR: state_next = tms_s ? EX1_IR : SH_IR;
      SH_IR:  state_next = tms_s ? EX1_IR : SH_IR;
      EX1_IR: state_next = tms_s ? UPD_IR : PAU_IR;
      PAU_IR: state_next = tms_s ? EX2_IR : PAU_IR;
      EX2_IR: state_next = tms_s ? UPD_IR : SH_IR;
      UPD_IR: state_next = tms_s ? SEL_DR : RTI;
      default: state_next = TLR;
    endcase
  end

  // right shift of the selected data register; tdi enters at that register's MSB
  always_comb begin
    dr_next = dr_sr >> 1;
    dr_next[is_user ? USER_MSB : 5'd31] = tdi_s;
  end

  // instruction register path: capture/shift on rise, update on fall
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      ir_sr <= '0;
      ir_o  <= OP_IDCODE;
    end else begin
      if (rise && state == TLR) ir_o <= OP_IDCODE;
      if (rise && state == CAP_IR) ir_sr <= IR_LEN'(1);
      if (rise && state == SH_IR) ir_sr <= {tdi_s, ir_sr[IR_LEN-1:1]};
      if (fall && state == UPD_IR) ir_o <= ir_sr;
    end

  // data register path: capture/shift on rise, user update on fall
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      dr_sr          <= '0;
      bp             <= 1'b0;
      user_dr_o      <= '0;
      user_capture_o <= 1'b0;
      user_update_o  <= 1'b0;
    end else begin
      user_capture_o <= rise && state == CAP_DR && is_user;
      user_update_o  <= fall && state == UPD_DR && is_user;
      if (rise && state == CAP_DR) begin
        if (is_id) dr_sr <= IDCODE_VAL;
        else if (is_user) dr_sr <= 32'(user_dr_i);
        else bp <= 1'b0;
      end
      if (rise && state == SH_DR) begin
        if (is_id || is_user) dr_sr <= dr_next;
        else bp <= tdi_s;
      end
      if (fall && state == UPD_DR && is_user) user_dr_o <= dr_sr[USER_DR_LEN-1:0];
    end

  // TDO and its enable change only on a fall, and only shift states present new data
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else if (fall) begin
      tdo_oe_o <= state == SH_IR || state == SH_DR;
      if (state == SH_IR) tdo_o <= ir_sr[0];
      if (state == SH_DR) tdo_o <= (is_id || is_user) ? dr_sr[0] : bp;
    end
endmodule

// File: tb/tb_jtag_tap_target.sv
// tb_jtag_tap_target: randomized and directed checks of the TAP responder against a table-driven TAP model
module tb_jtag_tap_target;
  localparam int H = 4;
  localparam logic [31:0] IDCODE = 32'h1234_5093;

  logic clk_i = 1'b0, reset_i = 1'b1, tck_i = 1'b0, tms_i = 1'b0, tdi_i = 1'b0;
  logic tdo_o, tdo_oe_o, user_capture_o, user_update_o;
  logic [3:0] tap_state_o, ir_o;
  logic [31:0] user_dr_i = '0, user_dr_o;

  jtag_tap_target dut (
    .clk_i(clk_i), .reset_i(reset_i), .tck_i(tck_i), .tms_i(tms_i), .tdi_i(tdi_i),
    .tdo_o(tdo_o), .tdo_oe_o(tdo_oe_o), .tap_state_o(tap_state_o), .ir_o(ir_o),
    .user_dr_i(user_dr_i), .user_dr_o(user_dr_o),
    .user_capture_o(user_capture_o), .user_update_o(user_update_o)
  );

  always #5 clk_i = ~clk_i;

  // reference TAP: next state indexed by current state, for TMS=0 and TMS=1
  logic [3:0] n0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                          4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
  logic [3:0] n1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                          4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
  logic [3:0] ms = 4'hF;

  int checks = 0, errors = 0;
  int cap_cnt = 0, upd_cnt = 0;

  // count cycles each pulse is high, so a pulse longer than one cycle shows up as an extra count
  always @(posedge clk_i) begin
    if (user_capture_o) cap_cnt <= cap_cnt + 1;
    if (user_update_o) upd_cnt <= upd_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one TCK period; returns TDO/OE as seen just before the rise and checks the state against the model
  task automatic tick(input logic tms, input logic tdi, output logic so, output logic oe);
    tms_i = tms;
    tdi_i = tdi;
    repeat (H) @(posedge clk_i);
    @(negedge clk_i);
    so = tdo_o;
    oe = tdo_oe_o;
    check("state", 64'(tap_state_o), 64'(ms));
    ms = tms ? n1[ms] : n0[ms];
    tck_i = 1'b1;
    repeat (H) @(posedge clk_i);
    @(negedge clk_i);
    tck_i = 1'b0;
  endtask

  task automatic tk(input logic tms, input logic tdi);
    logic so, oe;
    tick(tms, tdi, so, oe);
  endtask

  task automatic scan_ir(input logic [3:0] v, output logic [3:0] o);
    logic so, oe;
    tk(1, 0); tk(1, 0); tk(0, 0); tk(0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, v[i], so, oe);
      o[i] = so;
    end
    tk(1, 0); tk(0, 0);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] v, output logic [63:0] o, output logic oe_all);
    logic so, oe;
    o = '0;
    oe_all = 1'b1;
    tk(1, 0); tk(0, 0); tk(0, 0);
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, v[i], so, oe);
      o[i] = so;
      oe_all &= oe;
    end
    tk(1, 0); tk(0, 0);
  endtask

  initial begin
    logic [3:0] o4;
    logic [63:0] o;
    logic oe_all;
    int c0, u0;
    repeat (3) @(negedge clk_i);
    check("rst_state", 64'(tap_state_o), 64'hF);
    check("rst_ir", 64'(ir_o), 64'h1);
    check("rst_tdo", 64'(tdo_o), 64'h0);
    check("rst_oe", 64'(tdo_oe_o), 64'h0);
    check("rst_udr", 64'(user_dr_o), 64'h0);
    reset_i = 1'b0;

    for (int i = 0; i < 5; i++) tk(1, 0);
    check("t1_ir", 64'(ir_o), 64'h1);
    check("t1_oe", 64'(tdo_oe_o), 64'h0);

    tk(0, 0);
    scan_dr(32, 64'h0, o, oe_all);
    check("idcode", o, 64'(IDCODE));
    check("idcode_oe", 64'(oe_all), 64'h1);
    check("oe_after", 64'(tdo_oe_o), 64'h0);

    scan_ir(4'hF, o4);
    check("ir_capture", 64'(o4), 64'h1);
    check("ir_bypass", 64'(ir_o), 64'hF);
    scan_dr(9, 64'hA5, o, oe_all);
    check("bypass", o, 64'h14A);

    user_dr_i = 32'hDEAD_BEEF;
    scan_ir(4'h2, o4);
    check("ir_capture2", 64'(o4), 64'h1);
    check("ir_user", 64'(ir_o), 64'h2);
    c0 = cap_cnt;
    u0 = upd_cnt;
    scan_dr(32, 64'hCAFE_F00D, o, oe_all);
    check("user_out", o, 64'hDEAD_BEEF);
    check("cap_pulse", 64'(cap_cnt - c0), 64'h1);
    check("upd_pulse", 64'(upd_cnt - u0), 64'h1);
    check("user_dr_o", 64'(user_dr_o), 64'hCAFE_F00D);

    reset_i = 1'b1;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    ms = 4'hF;
    check("rst2_udr", 64'(user_dr_o), 64'h0);
    tk(0, 0);
    scan_ir(4'h2, o4);
    u0 = upd_cnt;
    tk(1, 0); tk(0, 0); tk(0, 0);
    for (int i = 0; i < 10; i++) tk(0, 1'($urandom));
    reset_i = 1'b1;
    ms = 4'hF;
    repeat (2) @(negedge clk_i);
    check("t5_state", 64'(tap_state_o), 64'hF);
    check("t5_ir", 64'(ir_o), 64'h1);
    check("t5_oe", 64'(tdo_oe_o), 64'h0);
    reset_i = 1'b0;
    repeat (2 * H) @(negedge clk_i);
    check("t5_udr", 64'(user_dr_o), 64'h0);
    check("t5_no_upd", 64'(upd_cnt - u0), 64'h0);

    for (int i = 0; i < 1000; i++) begin
      user_dr_i = $urandom;
      tk(1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 5; i++) tk(1, 1'($urandom));
    repeat (H) @(negedge clk_i);
    check("t6_tlr", 64'(tap_state_o), 64'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
